// File: rtl/dwt_pkg.sv
// Shared definitions for the DWT row scheduler: default geometry, FSM state
// encoding and the memory address width helper.
package dwt_pkg;

  localparam int LENGTH_DEF = 256;
  localparam int ROWS_DEF   = 256;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    COLLECT,
    NEXT
  } sched_state_t;

  function automatic int addr_w(input int length, input int rows);
    return $clog2(length * rows);
  endfunction

endpackage

// File: rtl/dwt_row_scheduler_if.sv
// Bundle between the row scheduler, the image memories and the row processor.
// master = scheduler side, slave = environment side.
interface dwt_row_scheduler_if #(
  parameter int LENGTH = dwt_pkg::LENGTH_DEF,
  parameter int ROWS   = dwt_pkg::ROWS_DEF
);
  localparam int AW = dwt_pkg::addr_w(LENGTH, ROWS);

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic [7:0]              rd_data;
  logic [LENGTH-1:0][7:0]  row_buf;
  logic                    rp_en;
  logic                    rp_result;
  logic [7:0]              rp_s;
  logic [7:0]              rp_d;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr_s;
  logic [AW-1:0]           wr_addr_d;
  logic [7:0]              wr_s;
  logic [7:0]              wr_d;

  modport master (
    input  start, rd_data, rp_result, rp_s, rp_d,
    output busy, done, err, rd_en, rd_addr, row_buf, rp_en,
           wr_en, wr_addr_s, wr_addr_d, wr_s, wr_d
  );

  modport slave (
    output start, rd_data, rp_result, rp_s, rp_d,
    input  busy, done, err, rd_en, rd_addr, row_buf, rp_en,
           wr_en, wr_addr_s, wr_addr_d, wr_s, wr_d
  );

endinterface

// File: rtl/dwt_row_scheduler_row_loader.sv
// Streams one image row out of the source memory and captures it into row_buf.
// A kick starts LENGTH read strobes from base; load_done marks the final capture cycle.
module dwt_row_scheduler_row_loader
  import dwt_pkg::*;
#(
  parameter int LENGTH = LENGTH_DEF,
  parameter int AW     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   kick,
  input  logic [AW-1:0]          base,
  input  logic [7:0]             rd_data,
  output logic                   rd_en,
  output logic [AW-1:0]          rd_addr,
  output logic [LENGTH-1:0][7:0] row_buf,
  output logic                   load_done
);
  localparam int CW = $clog2(LENGTH) + 1;

  logic [CW-1:0] col;
  logic          cap_en;
  logic [CW-2:0] cap_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      col     <= '0;
      cap_en  <= 1'b0;
      cap_idx <= '0;
    end else begin
      cap_en  <= rd_en;
      cap_idx <= col[CW-2:0];
      if (kick) begin
        rd_en   <= 1'b1;
        rd_addr <= base;
        col     <= '0;
      end else if (rd_en) begin
        if (col == CW'(LENGTH - 1)) begin
          rd_en <= 1'b0;
        end else begin
          col     <= col + 1'b1;
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

  // Row storage is deliberately unreset; it is fully rewritten by every load.
  always_ff @(posedge clk) begin
    if (cap_en) row_buf[cap_idx] <= rd_data;
  end

  assign load_done = cap_en & ~rd_en;

endmodule

// File: rtl/dwt_row_scheduler.sv
// Row-by-row sequencer for a 1-D DWT row processor: load a row, fire the
// processor, write back its s/d pairs to split halves, repeat for every row.
//   state   | meaning
//   IDLE    | waiting for start
//   LOAD    | reading one row into row_buf
//   FIRE    | one-cycle rp_en pulse
//   COLLECT | writing s/d pairs, timeout armed until the first pair
//   NEXT    | advance row or finish image
module dwt_row_scheduler
  import dwt_pkg::*;
#(
  parameter int LENGTH  = LENGTH_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  dwt_row_scheduler_if.master bus
);
  localparam int AW  = addr_w(LENGTH, ROWS);
  localparam int LW  = $clog2(LENGTH);
  localparam int RW  = $clog2(ROWS);
  localparam int RCW = RW + 1;
  localparam int KW  = $clog2(LENGTH / 2) + 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  sched_state_t   state_q, state_d;
  logic [RCW-1:0] row_q, row_d;
  logic [KW-1:0]  k_q, k_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic           rp_en_q, rp_en_d, wr_en_q, wr_en_d;
  logic [AW-1:0]  wa_s_q, wa_s_d, wa_d_q, wa_d_d;
  logic [7:0]     ws_q, ws_d, wd_q, wd_d;
  logic           kick, load_done, rd_en;
  logic [AW-1:0]  base, rd_addr;
  logic [LENGTH-1:0][7:0] row_buf;

  assign base = {row_d[RW-1:0], {LW{1'b0}}};

  dwt_row_scheduler_row_loader #(.LENGTH(LENGTH), .AW(AW)) u_loader (
    .clk       (clk),
    .reset     (reset),
    .kick      (kick),
    .base      (base),
    .rd_data   (bus.rd_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .row_buf   (row_buf),
    .load_done (load_done)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = k_q;
    timer_d = timer_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    rp_en_d = 1'b0;
    wr_en_d = 1'b0;
    wa_s_d  = wa_s_q;
    wa_d_d  = wa_d_q;
    ws_d    = ws_q;
    wd_d    = wd_q;
    kick    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = LOAD;
        row_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        kick    = 1'b1;
      end
      LOAD: if (load_done) begin
        state_d = FIRE;
        rp_en_d = 1'b1;
      end
      FIRE: begin
        state_d = COLLECT;
        k_d     = '0;
        timer_d = '0;
      end
      COLLECT: begin
        if (bus.rp_result) begin
          wr_en_d = 1'b1;
          ws_d    = bus.rp_s;
          wd_d    = bus.rp_d;
          wa_s_d  = {row_q[RW-1:0], 1'b0, k_q[KW-2:0]};
          wa_d_d  = {row_q[RW-1:0], 1'b1, k_q[KW-2:0]};
          k_d     = k_q + 1'b1;
          if (k_q == KW'(LENGTH / 2 - 1)) state_d = NEXT;
        end else if (k_q == '0) begin
          // Only a processor that never answers is timed out; gaps later in the row are legal.
          if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      NEXT: begin
        if (row_q == RCW'(ROWS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = LOAD;
          row_d   = row_q + 1'b1;
          kick    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      k_q     <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rp_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      wa_s_q  <= '0;
      wa_d_q  <= '0;
      ws_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rp_en_q <= rp_en_d;
      wr_en_q <= wr_en_d;
      wa_s_q  <= wa_s_d;
      wa_d_q  <= wa_d_d;
      ws_q    <= ws_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_addr;
  assign bus.row_buf   = row_buf;
  assign bus.rp_en     = rp_en_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr_s = wa_s_q;
  assign bus.wr_addr_d = wa_d_q;
  assign bus.wr_s      = ws_q;
  assign bus.wr_d      = wd_q;

endmodule

// File: tb/tb_dwt_row_scheduler.sv
// Bench for dwt_row_scheduler: 8x2 image, behavioural memory and row processor,
// expected writes derived directly from the image with Haar-style s/d arithmetic.
module tb_dwt_row_scheduler;
  localparam int L  = 8;
  localparam int R  = 2;
  localparam int TO = 20;
  localparam int P  = 2;
  localparam int M_CONT = 0, M_TOG = 1, M_RAND = 2, M_NEVER = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dwt_row_scheduler_if #(.LENGTH(L), .ROWS(R)) bus ();

  dwt_row_scheduler #(.LENGTH(L), .ROWS(R), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] img [L*R];
  int mode = M_CONT;

  // per-run observation counters, written only by the main initial block
  int rd_idx, wr_idx, rp_idx, done_cnt;

  // source memory: data valid one cycle after the read strobe
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= img[bus.rd_addr];
  end

  // behavioural row processor, drives its outputs on the falling edge
  int p_wt, p_idx, p_lim;
  bit p_act, p_ph, p_emit;
  logic [L-1:0][7:0] p_snap;
  logic [7:0] p_a, p_b;
  always @(negedge clk) begin
    if (reset) begin
      p_act = 1'b0;
      bus.rp_result = 1'b0;
      bus.rp_s = 8'h00;
      bus.rp_d = 8'h00;
    end else begin
      bus.rp_result = 1'b0;
      if (p_act) begin
        if (p_wt > 0) p_wt--;
        if (p_wt == 0 && p_idx < p_lim) begin
          case (mode)
            M_CONT:  p_emit = 1'b1;
            M_TOG:   p_emit = ~p_ph;
            M_RAND:  p_emit = (p_idx == 0) || ($urandom_range(0, 1) == 1);
            default: p_emit = 1'b0;
          endcase
          p_ph = ~p_ph;
          if (p_emit) begin
            p_a = p_snap[2*(p_idx%4)];
            p_b = p_snap[2*(p_idx%4)+1];
            bus.rp_result = 1'b1;
            bus.rp_s = 8'((9'(p_a) + 9'(p_b)) >> 1);
            bus.rp_d = p_a - p_b;
            p_idx++;
          end
        end
      end
      if (bus.rp_en) begin
        p_act  = 1'b1;
        p_wt   = P;
        p_idx  = 0;
        p_ph   = 1'b0;
        p_snap = bus.row_buf;
        p_lim  = (mode == M_CONT) ? L/2 + 1 : L/2;  // one surplus pair must be ignored
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance one clock and observe every output stream against the image model
  task automatic step();
    logic [L-1:0][7:0] e_row;
    int r, k;
    logic [7:0] a, b, es, ed;
    @(posedge clk);
    #1;
    if (bus.rd_en) begin
      check("rd_addr", 64'(bus.rd_addr), 64'(rd_idx));
      rd_idx++;
    end
    if (bus.rp_en) begin
      for (int j = 0; j < L; j++) e_row[j] = img[(rp_idx % R)*L + j];
      check("row_buf_at_fire", 64'(bus.row_buf), 64'(e_row));
      rp_idx++;
    end
    if (bus.wr_en) begin
      if (wr_idx < L*R/2) begin
        r = wr_idx / (L/2);
        k = wr_idx % (L/2);
        a = img[r*L + 2*k];
        b = img[r*L + 2*k + 1];
        es = 8'((9'(a) + 9'(b)) >> 1);
        ed = a - b;
        check("write_pair", {40'd0, bus.wr_addr_s, bus.wr_addr_d, bus.wr_s, bus.wr_d},
              {40'd0, 4'(r*L + k), 4'(r*L + L/2 + k), es, ed});
      end
      wr_idx++;
    end
    if (bus.done) begin
      done_cnt++;
      check("busy_at_done", 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic start_pulse();
    rd_idx = 0; wr_idx = 0; rp_idx = 0; done_cnt = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_to_end(input int budget);
    bit ended = 1'b0;
    for (int i = 0; i < budget && !ended; i++) begin
      step();
      if (bus.done || bus.err) ended = 1'b1;
    end
    check("run_ended", 64'(ended), 64'd1);
    repeat (4) step();
  endtask

  task automatic wait_rp_en(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (bus.rp_en) seen = 1'b1;
    end
    check("rp_en_seen", 64'(seen), 64'd1);
  endtask

  typedef struct {
    int mode;
    bit rnd_img;
    int rows;
    int writes;
    int dones;
    bit err;
  } vec_t;
  vec_t vecs [6];

  initial begin
    int n;
    bit hit;
    vecs[0] = '{M_CONT,  1'b0, 2, 8, 1, 1'b0};
    vecs[1] = '{M_TOG,   1'b0, 2, 8, 1, 1'b0};
    vecs[2] = '{M_RAND,  1'b1, 2, 8, 1, 1'b0};
    vecs[3] = '{M_CONT,  1'b1, 2, 8, 1, 1'b0};
    vecs[4] = '{M_NEVER, 1'b0, 1, 0, 0, 1'b1};
    vecs[5] = '{M_CONT,  1'b0, 2, 8, 1, 1'b0};

    bus.start = 1'b0;
    for (int i = 0; i < L*R; i++) img[i] = 8'(i);
    rd_idx = 0; wr_idx = 0; rp_idx = 0; done_cnt = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  64'(bus.busy),  64'd0);
    check("rst_done",  64'(bus.done),  64'd0);
    check("rst_err",   64'(bus.err),   64'd0);
    check("rst_rd_en", 64'(bus.rd_en), 64'd0);
    check("rst_rp_en", 64'(bus.rp_en), 64'd0);
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_addrs", {52'd0, bus.rd_addr, bus.wr_addr_s, bus.wr_addr_d}, 64'd0);
    check("rst_wdata", {48'd0, bus.wr_s, bus.wr_d}, 64'd0);
    reset = 1'b0;
    step();

    foreach (vecs[v]) begin
      mode = vecs[v].mode;
      for (int i = 0; i < L*R; i++) img[i] = vecs[v].rnd_img ? 8'($urandom) : 8'(i);
      start_pulse();
      run_to_end(400);
      check($sformatf("v%0d_writes", v), 64'(wr_idx),   64'(vecs[v].writes));
      check($sformatf("v%0d_done", v),   64'(done_cnt), 64'(vecs[v].dones));
      check($sformatf("v%0d_err", v),    64'(bus.err),  64'(vecs[v].err));
      check($sformatf("v%0d_busy", v),   64'(bus.busy), 64'd0);
      check($sformatf("v%0d_reads", v),  64'(rd_idx),   64'(vecs[v].rows * L));
      check($sformatf("v%0d_fires", v),  64'(rp_idx),   64'(vecs[v].rows));
    end

    // timeout: err is visible on the edge closing the TO-th COLLECT cycle
    for (int i = 0; i < L*R; i++) img[i] = 8'(i);
    mode = M_NEVER;
    start_pulse();
    wait_rp_en(50);
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      n++;
      if (bus.err) hit = 1'b1;
    end
    check("timeout_edges", 64'(n), 64'(TO + 1));
    check("timeout_busy",  64'(bus.busy), 64'd0);
    repeat (3) step();
    check("timeout_no_done", 64'(done_cnt), 64'd0);
    mode = M_CONT;
    start_pulse();
    check("err_cleared_by_start", {62'd0, bus.err, bus.busy}, 64'd1);
    run_to_end(400);
    check("after_timeout_writes", 64'(wr_idx), 64'd8);

    // start pulsed during LOAD must not disturb the row read
    start_pulse();
    repeat (3) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_to_end(400);
    check("start_in_load_reads",  64'(rd_idx),   64'd16);
    check("start_in_load_writes", 64'(wr_idx),   64'd8);
    check("start_in_load_done",   64'(done_cnt), 64'd1);

    // reset in COLLECT of row 0
    start_pulse();
    wait_rp_en(50);
    step();
    #2 reset = 1'b1;
    #1;
    check("rst_mid_strobes", {59'd0, bus.rd_en, bus.wr_en, bus.rp_en, bus.busy, bus.done}, 64'd0);
    n = wr_idx;
    repeat (5) step();
    check("rst_mid_no_writes", 64'(wr_idx), 64'(n));
    check("rst_mid_no_done",   64'(done_cnt), 64'd0);
    reset = 1'b0;
    repeat (2) step();
    start_pulse();
    check("restart_rd", {59'd0, bus.rd_en, bus.rd_addr}, 64'h10);
    run_to_end(400);
    check("restart_writes", 64'(wr_idx), 64'd8);
    check("restart_done",   64'(done_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dwt_row_scheduler.md
DWT_ROW_SCHEDULER -- requirements
Module: dwt_row_scheduler

Interface
REQ-001 Parameter LENGTH, default 256, samples per row; even, power of two.
REQ-002 Parameter ROWS, default 256, rows per image.
REQ-003 Parameter TIMEOUT, default 1023, max cycles from rp_en to first rp_result.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse, begin image transform.
REQ-007 busy  out  1  high from accepted start until done.
REQ-008 done  out  1  one-cycle pulse, image complete.
REQ-009 err  out  1  sticky timeout flag, cleared by next accepted start.
REQ-010 rd_en  out  1  source image memory read strobe.
REQ-011 rd_addr  out  log2(LENGTH*ROWS)  read address, row*LENGTH+col.
REQ-012 rd_data  in  8  read data, valid exactly 1 cycle after rd_en.
REQ-013 row_buf  out  LENGTH x 8  row vector driven to row_processor in.
REQ-014 rp_en  out  1  one-cycle start pulse to row_processor.
REQ-015 rp_result  in  1  row_processor output-valid, one s/d pair per high cycle.
REQ-016 rp_s, rp_d  in  8 each  row_processor approximation/detail samples.
REQ-017 wr_en  out  1  destination memory write strobe (dual write).
REQ-018 wr_addr_s, wr_addr_d  out  log2(LENGTH*ROWS) each  s at row*LENGTH+k, d at row*LENGTH+LENGTH/2+k.
REQ-019 wr_s, wr_d  out  8 each  registered copies of rp_s, rp_d.

Function
REQ-020 FSM states IDLE, LOAD, FIRE, COLLECT, NEXT; IDLE after reset.
REQ-021 IDLE: start -> LOAD, row=0, col=0, err cleared, busy=1 next cycle.
REQ-022 start while busy ignored, no effect on any counter.
REQ-023 LOAD: rd_en=1 for LENGTH consecutive cycles, col 0..LENGTH-1; rd_data captured into row_buf[col] one cycle later.
REQ-024 LOAD lasts LENGTH+1 cycles (last capture in final cycle), then FIRE.
REQ-025 FIRE: rp_en=1 for exactly one cycle, row_buf stable; -> COLLECT, k=0, timer=0.
REQ-026 row_buf held constant from end of LOAD until next row's LOAD begins.
REQ-027 COLLECT: each rp_result=1 cycle -> next cycle wr_en=1, wr_s/wr_d=rp_s/rp_d, addresses from k; k increments.
REQ-028 COLLECT: rp_result may be non-contiguous; gaps produce no write.
REQ-029 COLLECT exits to NEXT on the cycle the LENGTH/2-th pair is captured; rp_result beyond that ignored.
REQ-030 Timer counts COLLECT cycles with k=0; reaching TIMEOUT -> err=1, busy=0, IDLE, no done.
REQ-031 NEXT (1 cycle): row==ROWS-1 -> done=1, busy=0, IDLE; else row++, col=0, LOAD.
REQ-032 Counter widths: col log2(LENGTH)+1, k log2(LENGTH/2)+1, row log2(ROWS)+1; no wrap inside a row.
REQ-033 Address arithmetic unsigned, computed by shift/concatenate (row, col), no multiplier.
REQ-034 Per-row latency with contiguous rp_result of delay P after rp_en: LENGTH+1+1+P+LENGTH/2+1 cycles.

Reset
REQ-035 reset asynchronously forces IDLE; busy, done, err, rd_en, rp_en, wr_en = 0; counters, addresses, wr_s, wr_d = 0.
REQ-036 row_buf not reset; contents undefined until first LOAD.
REQ-037 reset mid-operation: no further rd_en/wr_en, no done; new start required after release.

Structure
REQ-038 Package dwt_pkg holds LENGTH, ROWS defaults, state enum sched_state_t, address-width function.
REQ-039 One sub-module natural: row_loader (LOAD counter, read strobe, capture into row_buf).
REQ-040 All outputs registered; no combinational path rp_result -> wr_en.

Verification
REQ-041 LENGTH=8, ROWS=2, ramp image 0..15, behavioural row_processor P=2 -> 8 writes, done after 2 rows, busy low same cycle.
REQ-042 rd_data pattern: row_buf after LOAD of row 1 equals image bytes 8..15 exactly.
REQ-043 rp_result toggling 1/0 -> 4 writes per row, k addresses 0..3 s, 4..7 d, no duplicates.
REQ-044 rp_result never asserted, TIMEOUT=20 -> err=1 at cycle 20 of COLLECT, IDLE, done never pulses; next start clears err.
REQ-045 reset asserted during COLLECT row 0 -> all strobes 0 immediately, IDLE; start after release rereads from address 0.
REQ-046 start pulsed during LOAD -> ignored; rd_addr sequence uninterrupted.
